ps_ddr_axi_bridge: RTL
======================

PS_DDR_AXI_BRIDGE -- requirements
Module: ps_ddr_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 49, AXI address width, equal to the command address field width.
REQ-002 SHALL have parameter DATA_W, default 128, data width of the FIFOs and AXI data; fixed 16-byte beats.
REQ-003 SHALL have one clock and asynchronous active-low reset:
  - clk  in  1  single clock for all logic
  - rst_n  in  1  asynchronous active-low reset
REQ-004 SHALL have these command FIFO ports (first-word-fall-through):
  - fifo_dout_cmd  in  64  command: [63]=read(1)/write(0), [62:61] reserved, [60:12] address, [11:0] byte length-1
  - fifo_empty_cmd  in  1  command FIFO empty
  - fifo_rd_en_cmd  out  1  pop command
REQ-005 SHALL have these write-data FIFO ports (first-word-fall-through):
  - fifo_dout_wr  in  128  write beat
  - fifo_empty_wr  in  1  write-data FIFO empty
  - fifo_rd_en_wr  out  1  pop write beat
REQ-006 SHALL have these read-data FIFO ports:
  - fifo_din_rd  out  128  read beat
  - fifo_wr_en_rd  out  1  push read beat
  - fifo_full_rd  in  1  read-data FIFO full
REQ-007 SHALL have an AXI4 master interface:
  - AW: awaddr[ADDR_W], awlen[8], awsize[3], awburst[2], awvalid, awready
  - W: wdata[128], wstrb[16], wlast, wvalid, wready
  - B: bresp[2], bvalid, bready
  - AR: araddr, arlen, arsize, arburst, arvalid, arready
  - R: rdata, rresp[2], rlast, rvalid, rready
REQ-008 SHALL have these status outputs:
  - busy  out  1  FSM not IDLE
  - wr_burst_cnt  out  32  completed write bursts
  - rd_burst_cnt  out  32  completed read bursts
  - resp_err  out  1  sticky error flag

Function
REQ-009 SHALL implement states IDLE, WR_BURST, WR_RESP, RD_ADDR, RD_DATA.
REQ-010 In IDLE with fifo_empty_cmd=0, SHALL pulse fifo_rd_en_cmd for one cycle, latch the command, and enter WR_BURST (bit63=0) or RD_ADDR (bit63=1) next cycle.
REQ-011 SHALL drive awlen/arlen = cmd[11:4]; cmd[3:0] ignored; awsize/arsize=3'b100; awburst/arburst=2'b01; wstrb=16'hFFFF.
REQ-012 SHALL drive awaddr/araddr = cmd[60:12] registered, held stable while valid.
REQ-013 WR_BURST: SHALL assert awvalid from entry until the awready handshake, then deassert; W SHALL proceed concurrently with AW.
REQ-014 WR_BURST: wvalid SHALL equal (beats sent ≤ awlen) AND NOT fifo_empty_wr; wdata SHALL equal fifo_dout_wr; fifo_rd_en_wr SHALL equal wvalid AND wready.
REQ-015 SHALL assert wlast on the beat with index == awlen; beat counter is 9 bits, so awlen=255 gives 256 beats with no wrap.
REQ-016 SHALL leave WR_BURST for WR_RESP only when both the AW handshake and the wlast handshake have occurred, in either order or the same cycle.
REQ-017 WR_RESP: SHALL hold bready=1; on bvalid, return to IDLE and increment wr_burst_cnt; bresp≠2'b00 SHALL set resp_err.
REQ-018 RD_ADDR: SHALL hold arvalid until arready, then enter RD_DATA.
REQ-019 RD_DATA: rready SHALL equal NOT fifo_full_rd; fifo_wr_en_rd SHALL equal rvalid AND rready; fifo_din_rd SHALL equal rdata.
REQ-020 On the rlast handshake, SHALL return to IDLE and increment rd_burst_cnt.
REQ-021 SHALL set resp_err on rresp≠2'b00, on rlast before beat index arlen, or on beat index arlen without rlast.
REQ-022 bready SHALL be 0 outside WR_RESP; rready SHALL be 0 outside RD_DATA.
REQ-023 SHALL accept no new command until the current burst completes; exactly one outstanding transaction.
REQ-024 Counters SHALL wrap modulo 2^32.
REQ-025 resp_err SHALL be sticky and cleared only by reset.

Reset
REQ-026 rst_n low SHALL immediately force IDLE and set all valid, ready and enable outputs, counters, resp_err and busy to 0.
REQ-027 A reset mid-burst SHALL abandon the burst; recovery of the FIFOs and slave is the system's responsibility.

Verification
REQ-028 Write cmd {0,2'b0,'h7000_0000,12'hfff} with 256 beats prefilled, slave always ready -> AW awaddr=0x7000_0000, awlen=255; 256 W beats; wlast on beat 256 only; wr_burst_cnt=1.
REQ-029 Read cmd {1,...,'h7000_0000,12'hfff}, slave returns 256 beats with rlast on the last -> 256 pushes into the read FIFO, data matching rdata; rd_burst_cnt=1; resp_err=0.
REQ-030 Write with the data FIFO empty for 10 cycles mid-burst and random wready -> wvalid low while empty, no beat lost or duplicated, wlast still on beat 256.
REQ-031 fifo_full_rd held high 20 cycles during a read -> rready=0 and no pushes; burst resumes and completes intact.
REQ-032 bresp=2'b10 on a write, then a read whose rlast arrives at beat 100 -> resp_err=1 after the first error, remains 1; FSM returns to IDLE both times.
REQ-033 rst_n asserted at write beat 50 -> all outputs 0 same cycle; after release, a new command executes normally.

Source files
------------

// File: rtl/ps_ddr_axi_bridge_if.sv
// AXI4 bus between the PS DDR bridge (master) and the memory-side slave.
// Fixed 16-byte beats; only incrementing bursts are issued.
interface ps_ddr_axi_bridge_if #(
  parameter int ADDR_W = 49,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/ps_ddr_axi_bridge.sv
// Turns commands from a FWFT command FIFO into single AXI4 bursts, streaming
// write beats from a data FIFO and pushing read beats into a read FIFO.
module ps_ddr_axi_bridge #(
  parameter int ADDR_W = 49,
  parameter int DATA_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          fifo_dout_cmd,
  input  logic                 fifo_empty_cmd,
  output logic                 fifo_rd_en_cmd,
  input  logic [DATA_W-1:0]    fifo_dout_wr,
  input  logic                 fifo_empty_wr,
  output logic                 fifo_rd_en_wr,
  output logic [DATA_W-1:0]    fifo_din_rd,
  output logic                 fifo_wr_en_rd,
  input  logic                 fifo_full_rd,
  ps_ddr_axi_bridge_if.master  axi,
  output logic                 busy,
  output logic [31:0]          wr_burst_cnt,
  output logic [31:0]          rd_burst_cnt,
  output logic                 resp_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    WR_RESP  = 3'd2,
    RD_ADDR  = 3'd3,
    RD_DATA  = 3'd4
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [8:0]        beat_r;
  logic              aw_done_r;
  logic              awvalid_r;
  logic              arvalid_r;
  logic              bready_r;
  logic              busy_r;
  logic [31:0]       wr_cnt_r;
  logic [31:0]       rd_cnt_r;
  logic              err_r;

  logic w_open_s;
  logic wvalid_s;
  logic wlast_s;
  logic w_hs_s;
  logic aw_hs_s;
  logic rready_s;
  logic r_hs_s;
  logic last_beat_s;
  logic unused_s;

  // Beat-level handshake qualifiers; the 9-bit beat index lets awlen=255 reach 256 beats.
  always_comb begin
    last_beat_s = (beat_r == {1'b0, len_r});
    w_open_s    = (state_r == WR_BURST) && (beat_r <= {1'b0, len_r});
    wvalid_s    = w_open_s && !fifo_empty_wr;
    wlast_s     = w_open_s && last_beat_s;
    w_hs_s      = wvalid_s && axi.wready;
    aw_hs_s     = awvalid_r && axi.awready;
    rready_s    = (state_r == RD_DATA) && !fifo_full_rd;
    r_hs_s      = rready_s && axi.rvalid;
  end

  // Burst sequencer: one outstanding transaction, AW and W run independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      len_r     <= 8'd0;
      beat_r    <= 9'd0;
      aw_done_r <= 1'b0;
      awvalid_r <= 1'b0;
      arvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
      wr_cnt_r  <= 32'd0;
      rd_cnt_r  <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_cmd) begin
            addr_r    <= fifo_dout_cmd[12 +: ADDR_W];
            len_r     <= fifo_dout_cmd[11:4];
            beat_r    <= 9'd0;
            aw_done_r <= 1'b0;
            busy_r    <= 1'b1;
            if (fifo_dout_cmd[63]) begin
              arvalid_r <= 1'b1;
              state_r   <= RD_ADDR;
            end else begin
              awvalid_r <= 1'b1;
              state_r   <= WR_BURST;
            end
          end
        end
        WR_BURST: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            beat_r <= beat_r + 9'd1;
          end
          // Both the address and the final data beat may land in either order.
          if ((aw_done_r || aw_hs_s) &&
              ((beat_r > {1'b0, len_r}) || (w_hs_s && wlast_s))) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_r <= 1'b0;
            busy_r   <= 1'b0;
            wr_cnt_r <= wr_cnt_r + 32'd1;
            state_r  <= IDLE;
            if (axi.bresp != 2'b00) begin
              err_r <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            arvalid_r <= 1'b0;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs_s) begin
            beat_r <= beat_r + 9'd1;
            if ((axi.rresp != 2'b00) || (axi.rlast != last_beat_s)) begin
              err_r <= 1'b1;
            end
            if (axi.rlast) begin
              busy_r   <= 1'b0;
              rd_cnt_r <= rd_cnt_r + 32'd1;
              state_r  <= IDLE;
            end
          end
        end
        default: begin
          awvalid_r <= 1'b0;
          arvalid_r <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign axi.awaddr  = addr_r;
  assign axi.awlen   = len_r;
  assign axi.awsize  = 3'b100;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_r;
  assign axi.wdata   = fifo_dout_wr;
  assign axi.wstrb   = {(DATA_W/8){1'b1}};
  assign axi.wlast   = wlast_s;
  assign axi.wvalid  = wvalid_s;
  assign axi.bready  = bready_r;
  assign axi.araddr  = addr_r;
  assign axi.arlen   = len_r;
  assign axi.arsize  = 3'b100;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_s;

  // The pop is gated by rst_n so it stays low while reset is held.
  assign fifo_rd_en_cmd = rst_n && (state_r == IDLE) && !fifo_empty_cmd;
  assign fifo_rd_en_wr  = w_hs_s;
  assign fifo_wr_en_rd  = r_hs_s;
  assign fifo_din_rd    = axi.rdata;

  assign busy         = busy_r;
  assign wr_burst_cnt = wr_cnt_r;
  assign rd_burst_cnt = rd_cnt_r;
  assign resp_err     = err_r;

  assign unused_s = ^{fifo_dout_cmd[62:61], fifo_dout_cmd[3:0]};

endmodule
